// File: rtl/fullchip_pkg.sv
// Shared definitions for fullchip_inst_seq: instruction field positions, widths and FSM states.
// The RDBK state exists only when SEQ_READBACK_EN is defined.
package fullchip_pkg;

  localparam int INST_W = 20;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 6;

  localparam int B_SFP_WR2PMEM = 19;
  localparam int B_SFP_DIV     = 18;
  localparam int B_SFP_ACC     = 17;
  localparam int B_OFIFO_RD    = 16;
  localparam int B_QK_ADD      = 12;
  localparam int B_PMEM_ADD    = 8;
  localparam int B_EXECUTE     = 7;
  localparam int B_LOAD        = 6;
  localparam int B_QMEM_RD     = 5;
  localparam int B_QMEM_WR     = 4;
  localparam int B_KMEM_RD     = 3;
  localparam int B_KMEM_WR     = 2;
  localparam int B_PMEM_RD     = 1;
  localparam int B_PMEM_WR     = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_KLOAD,
    S_GAP1,
    S_EXEC,
    S_GAP2,
    S_OFIFO,
`ifdef SEQ_READBACK_EN
    S_RDBK,
`endif
    S_ACC,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_step_cnt.sv
// Per-state step counter: down-counting remaining cycles with terminal-count flag, an up-count
// of elapsed steps, and an ascending address that optionally holds each value for two steps.
module seq_step_cnt #(
  parameter int CW = 6,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  input  logic          addr_en,
  input  logic          hold2,
  output logic [CW-1:0] step,
  output logic [AW-1:0] addr,
  output logic          tc
);

  logic [CW-1:0] rem;
  logic          phase;

  assign tc = (rem == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rem   <= '0;
      step  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (load) begin
      rem   <= load_val;
      step  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (en && !tc) begin
      rem  <= rem - CW'(1);
      step <= step + CW'(1);
      if (addr_en) begin
        // in hold2 mode the address advances on every second step
        phase <= hold2 & ~phase;
        if (!hold2 || phase) addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/fullchip_inst.sv
// fullchip_inst_seq: walks the fullchip through Q/K write, K load, execute, psum readout and SFP
// phases, emitting one registered instruction word per cycle. SEQ_READBACK_EN adds an RDBK phase.
//
// state  | meaning
// IDLE   | waiting for start
// QWR    | write total_cycle Q rows as the host supplies them
// KWR    | write col K rows as the host supplies them
// KLOAD  | load K into the array (col+2 cycles)
// GAP1   | idle gap after load
// EXEC   | stream Q rows through the array
// GAP2   | idle gap after execute
// OFIFO  | drain output fifo into psum memory
// RDBK   | optional psum readback, two cycles per address
// ACC    | SFP accumulate, two cycles per address
// DIV    | two settle cycles, then SFP divide with write-back
// DONE   | one-cycle completion pulse
module fullchip_inst_seq
  import fullchip_pkg::*;
#(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int gap_cycle   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              host_valid,
  output logic [INST_W-1:0] inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] row_idx,
  output logic              busy,
  output logic              done
);

  state_t              state, next_state;
  logic [INST_W-1:0]   inst_next;
  logic                cnt_load, cnt_en, cnt_addr_en, cnt_hold2, cnt_tc;
  logic [CNT_W-1:0]    cnt_len, cnt_step;
  logic [ADDR_W-1:0]   cnt_addr;

  function automatic logic [CNT_W-1:0] state_len_m1(input state_t s);
    int n;
    case (s)
      S_QWR, S_EXEC, S_OFIFO: n = total_cycle;
      S_KWR:                  n = col;
      S_KLOAD:                n = col + 2;
      S_GAP1, S_GAP2:         n = gap_cycle;
`ifdef SEQ_READBACK_EN
      S_RDBK:                 n = 2 * total_cycle;
`endif
      S_ACC:                  n = 2 * total_cycle;
      S_DIV:                  n = 2 * total_cycle + 2;
      default:                n = 1;
    endcase
    return CNT_W'(n - 1);
  endfunction

  seq_step_cnt #(.CW(CNT_W), .AW(ADDR_W)) u_step_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_len),
    .en       (cnt_en),
    .addr_en  (cnt_addr_en),
    .hold2    (cnt_hold2),
    .step     (cnt_step),
    .addr     (cnt_addr),
    .tc       (cnt_tc)
  );

  always_comb begin
    next_state  = state;
    inst_next   = '0;
    cnt_en      = 1'b1;
    cnt_addr_en = 1'b1;
    cnt_hold2   = 1'b0;
    mem_req     = 1'b0;
    row_idx     = '0;
    case (state)
      S_IDLE: if (start) next_state = S_QWR;
      S_QWR, S_KWR: begin
        // a low host_valid stalls the row index; there is no timeout
        mem_req = 1'b1;
        row_idx = cnt_addr;
        cnt_en  = host_valid;
        if (host_valid) begin
          inst_next[B_QK_ADD +: ADDR_W] = cnt_addr;
          if (state == S_QWR) inst_next[B_QMEM_WR] = 1'b1;
          else                inst_next[B_KMEM_WR] = 1'b1;
          if (cnt_tc) next_state = (state == S_QWR) ? S_KWR : S_KLOAD;
        end
      end
      S_KLOAD: begin
        inst_next[B_LOAD] = 1'b1;
        cnt_addr_en = (cnt_step != '0);
        if (cnt_step != '0 && cnt_step <= CNT_W'(col)) begin
          inst_next[B_KMEM_RD] = 1'b1;
          inst_next[B_QK_ADD +: ADDR_W] = cnt_addr;
        end
        if (cnt_tc) next_state = S_GAP1;
      end
      S_GAP1: if (cnt_tc) next_state = S_EXEC;
      S_EXEC: begin
        inst_next[B_EXECUTE] = 1'b1;
        inst_next[B_QMEM_RD] = 1'b1;
        inst_next[B_QK_ADD +: ADDR_W] = cnt_addr;
        if (cnt_tc) next_state = S_GAP2;
      end
      S_GAP2: if (cnt_tc) next_state = S_OFIFO;
      S_OFIFO: begin
        inst_next[B_OFIFO_RD] = 1'b1;
        inst_next[B_PMEM_WR]  = 1'b1;
        inst_next[B_PMEM_ADD +: ADDR_W] = cnt_addr;
`ifdef SEQ_READBACK_EN
        if (cnt_tc) next_state = S_RDBK;
      end
      S_RDBK: begin
        cnt_hold2 = 1'b1;
        inst_next[B_PMEM_RD] = 1'b1;
        inst_next[B_PMEM_ADD +: ADDR_W] = cnt_addr;
        if (cnt_tc) next_state = S_ACC;
`else
        if (cnt_tc) next_state = S_ACC;
`endif
      end
      S_ACC: begin
        cnt_hold2 = 1'b1;
        inst_next[B_PMEM_RD] = 1'b1;
        inst_next[B_SFP_ACC] = 1'b1;
        inst_next[B_PMEM_ADD +: ADDR_W] = cnt_addr;
        if (cnt_tc) next_state = S_DIV;
      end
      S_DIV: begin
        cnt_hold2   = 1'b1;
        cnt_addr_en = (cnt_step >= CNT_W'(2));
        inst_next[B_SFP_DIV] = 1'b1;
        if (cnt_step >= CNT_W'(2)) begin
          inst_next[B_PMEM_RD]     = 1'b1;
          inst_next[B_SFP_WR2PMEM] = 1'b1;
          inst_next[B_PMEM_ADD +: ADDR_W] = cnt_addr;
        end
        if (cnt_tc) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    cnt_load = (next_state != state);
    cnt_len  = state_len_m1(next_state);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      inst  <= '0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      inst  <= inst_next;
      done  <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// Directed bench for fullchip_inst_seq; cycle k is the k-th rising edge after the one sampling start.
module tb_fullchip_inst_seq;
  localparam int NCAP = 140;
`ifdef SEQ_READBACK_EN
  localparam int RB = 16;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, host_valid;
  logic [19:0] inst;
  logic        mem_req, busy, done;
  logic [3:0]  row_idx;

  logic [19:0] inst_tr [NCAP];
  logic        done_tr [NCAP];
  logic        busy_tr [NCAP];
  logic        req_tr  [NCAP];
  logic [3:0]  row_tr  [NCAP];
  int          done_at, done_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  fullchip_inst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .host_valid (host_valid),
    .inst       (inst),
    .mem_req    (mem_req),
    .row_idx    (row_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic capture_run(input bit stall, input bit extra_starts);
    @(negedge clk);
    start = 1'b1;
    host_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NCAP; k++) begin
      @(negedge clk);
      inst_tr[k] = inst;
      done_tr[k] = done;
      busy_tr[k] = busy;
      req_tr[k]  = mem_req;
      row_tr[k]  = row_idx;
      host_valid = !(stall && (k == 3 || k == 4 || k == 7 || k == 8));
      start      = extra_starts && (k == 5 || k == 30 || k == 60 || k == 96);
    end
    start = 1'b0;
    host_valid = 1'b1;
    done_at = -1;
    done_cnt = 0;
    for (int k = 0; k < NCAP; k++) begin
      if (done_tr[k] === 1'b1) begin
        if (done_at < 0) done_at = k;
        done_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    host_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (inst !== 20'h0 || busy !== 1'b0 || mem_req !== 1'b0 || row_idx !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: inst=%h busy=%b req=%b row=%0d done=%b, required all zero",
               inst, busy, mem_req, row_idx, done);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_full_run();
    logic [19:0] exp_v;
    capture_run(1'b0, 1'b0);
    n_tests++;
    if (inst_tr[0] !== 20'h0 || req_tr[0] !== 1'b1 || row_tr[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL cycle0: inst=%h req=%b row=%0d, required 00000/1/0", inst_tr[0], req_tr[0], row_tr[0]);
    end
    for (int i = 0; i < 8; i++) begin
      exp_v = 20'h00010 | (20'(i) << 12);
      n_tests++;
      if (inst_tr[1 + i] !== exp_v) begin
        n_fail++;
        $display("FAIL qwr[%0d]: inst=%h, required %h", i, inst_tr[1 + i], exp_v);
      end
      exp_v = 20'h00004 | (20'(i) << 12);
      n_tests++;
      if (inst_tr[9 + i] !== exp_v) begin
        n_fail++;
        $display("FAIL kwr[%0d]: inst=%h, required %h", i, inst_tr[9 + i], exp_v);
      end
      exp_v = 20'h000A0 | (20'(i) << 12);
      n_tests++;
      if (inst_tr[37 + i] !== exp_v) begin
        n_fail++;
        $display("FAIL exec[%0d]: inst=%h, required %h", i, inst_tr[37 + i], exp_v);
      end
      exp_v = 20'h10001 | (20'(i) << 8);
      n_tests++;
      if (inst_tr[55 + i] !== exp_v) begin
        n_fail++;
        $display("FAIL ofifo[%0d]: inst=%h, required %h", i, inst_tr[55 + i], exp_v);
      end
    end
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (inst_tr[27 + k] !== 20'h0 || inst_tr[45 + k] !== 20'h0) begin
        n_fail++;
        $display("FAIL gap[%0d]: gap1=%h gap2=%h, required 00000", k, inst_tr[27 + k], inst_tr[45 + k]);
      end
    end
    n_tests++;
    if (done_at !== 97 + RB || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL done_cycle: at=%0d count=%0d, required %0d/1", done_at, done_cnt, 97 + RB);
    end
    n_tests++;
    if (inst_tr[97 + RB] !== 20'h0 || busy_tr[96 + RB] !== 1'b1 || busy_tr[97 + RB] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_state: inst=%h busy96=%b busy97=%b, required 00000/1/0",
               inst_tr[97 + RB], busy_tr[96 + RB], busy_tr[97 + RB]);
    end
  endtask

  task automatic test_kload_window();
    logic [19:0] exp_v;
    int n_load;
    n_load = 0;
    for (int k = 0; k < NCAP; k++) if (inst_tr[k][6] === 1'b1) n_load++;
    n_tests++;
    if (n_load !== 10) begin
      n_fail++;
      $display("FAIL kload_len: load cycles=%0d, required 10", n_load);
    end
    n_tests++;
    if (inst_tr[17] !== 20'h00040 || inst_tr[26] !== 20'h00040) begin
      n_fail++;
      $display("FAIL kload_edges: first=%h last=%h, required 00040", inst_tr[17], inst_tr[26]);
    end
    for (int j = 1; j <= 8; j++) begin
      exp_v = 20'h00048 | (20'(j - 1) << 12);
      n_tests++;
      if (inst_tr[17 + j] !== exp_v) begin
        n_fail++;
        $display("FAIL kload[%0d]: inst=%h, required %h", j, inst_tr[17 + j], exp_v);
      end
    end
  endtask

  task automatic test_acc_div();
    logic [19:0] exp_v;
    int n_div, n_wb;
`ifdef SEQ_READBACK_EN
    for (int i = 0; i < 16; i++) begin
      exp_v = 20'h00002 | (20'(i >> 1) << 8);
      n_tests++;
      if (inst_tr[63 + i] !== exp_v) begin
        n_fail++;
        $display("FAIL rdbk[%0d]: inst=%h, required %h", i, inst_tr[63 + i], exp_v);
      end
    end
`endif
    for (int i = 0; i < 16; i++) begin
      exp_v = 20'h20002 | (20'(i >> 1) << 8);
      n_tests++;
      if (inst_tr[63 + RB + i] !== exp_v) begin
        n_fail++;
        $display("FAIL acc[%0d]: inst=%h, required %h", i, inst_tr[63 + RB + i], exp_v);
      end
      exp_v = 20'hC0002 | (20'(i >> 1) << 8);
      n_tests++;
      if (inst_tr[81 + RB + i] !== exp_v) begin
        n_fail++;
        $display("FAIL div[%0d]: inst=%h, required %h", i, inst_tr[81 + RB + i], exp_v);
      end
    end
    n_tests++;
    if (inst_tr[79 + RB] !== 20'h40000 || inst_tr[80 + RB] !== 20'h40000) begin
      n_fail++;
      $display("FAIL div_settle: %h %h, required 40000", inst_tr[79 + RB], inst_tr[80 + RB]);
    end
    n_div = 0;
    n_wb = 0;
    for (int k = 0; k < NCAP; k++) begin
      if (inst_tr[k][18] === 1'b1) n_div++;
      if (inst_tr[k][19] === 1'b1) n_wb++;
    end
    n_tests++;
    if (n_div !== 18 || n_wb !== 16) begin
      n_fail++;
      $display("FAIL div_counts: sfp_div=%0d wr2pmem=%0d, required 18/16", n_div, n_wb);
    end
  endtask

  task automatic test_qwr_stall();
    int qexp [12] = '{0, 1, 2, -1, -1, 3, 4, -1, -1, 5, 6, 7};
    logic [19:0] exp_v;
    capture_run(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      exp_v = (qexp[k] < 0) ? 20'h0 : (20'h00010 | (20'(qexp[k]) << 12));
      n_tests++;
      if (inst_tr[1 + k] !== exp_v) begin
        n_fail++;
        $display("FAIL stall_qwr[cycle %0d]: inst=%h, required %h", 1 + k, inst_tr[1 + k], exp_v);
      end
    end
    n_tests++;
    if (row_tr[3] !== 4'd3 || row_tr[4] !== 4'd3 || row_tr[7] !== 4'd5 || row_tr[8] !== 4'd5 ||
        req_tr[4] !== 1'b1 || req_tr[8] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_row_hold: rows=%0d,%0d,%0d,%0d req=%b,%b, required 3,3,5,5 req 1,1",
               row_tr[3], row_tr[4], row_tr[7], row_tr[8], req_tr[4], req_tr[8]);
    end
    n_tests++;
    if (inst_tr[13] !== 20'h00004) begin
      n_fail++;
      $display("FAIL stall_kwr_start: inst=%h, required 00004", inst_tr[13]);
    end
    n_tests++;
    if (done_at !== 101 + RB || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL stall_done: at=%0d count=%0d, required %0d/1", done_at, done_cnt, 101 + RB);
    end
  endtask

  task automatic test_back_to_back();
    int n_busy_after;
    capture_run(1'b0, 1'b1);
    n_tests++;
    if (done_at !== 97 + RB || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL busy_start_done: at=%0d count=%0d, required %0d/1", done_at, done_cnt, 97 + RB);
    end
    n_busy_after = 0;
    for (int k = 98 + RB; k < NCAP; k++) if (busy_tr[k] !== 1'b0) n_busy_after++;
    n_tests++;
    if (n_busy_after !== 0 || busy_tr[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_restart: busy cycles after done=%0d busy1=%b, required 0/1",
               n_busy_after, busy_tr[1]);
    end
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    start = 1'b1;
    host_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_tests++;
    if (inst !== 20'h040A0) begin
      n_fail++;
      $display("FAIL mid_exec_point: inst=%h, required 040a0", inst);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_exec_reset: inst=%h busy=%b done=%b req=%b, required all zero",
               inst, busy, done, mem_req);
    end
    reset = 1'b0;
    capture_run(1'b0, 1'b0);
    n_tests++;
    if (inst_tr[1] !== 20'h00010 || row_tr[0] !== 4'd0 || req_tr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL replay_start: inst=%h row=%0d req=%b, required 00010/0/1",
               inst_tr[1], row_tr[0], req_tr[0]);
    end
    n_tests++;
    if (done_at !== 97 + RB || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL replay_done: at=%0d count=%0d, required %0d/1", done_at, done_cnt, 97 + RB);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    host_valid = 1'b1;
    test_reset();
    test_full_run();
    test_kload_window();
    test_acc_div();
    test_qwr_stall();
    test_back_to_back();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fullchip_inst_seq.md
FULLCHIP_INST_SEQ -- requirements
Module: fullchip_inst_seq

Interface
- REQ-001 SHALL have parameter total_cycle, default 8, number of Q vectors streamed.
- REQ-002 SHALL have parameter col, default 8, number of K vectors (dot-product columns).
- REQ-003 SHALL have parameter gap_cycle, default 10, number of idle cycles after KLOAD and after EXEC.
- REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
- REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
- REQ-006 SHALL have port start, input, 1, run request; sampled only in IDLE.
- REQ-007 SHALL have port host_valid, input, 1, host presents the Q/K row indexed by row_idx on mem_in this cycle.
- REQ-008 SHALL have port inst, output, 20, fullchip instruction word; registered.
- REQ-009 SHALL have port mem_req, output, 1, sequencer is in QWR or KWR and wants row row_idx.
- REQ-010 SHALL have port row_idx, output, 4, index of requested Q/K row.
- REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
- REQ-012 SHALL have port done, output, 1, one-cycle pulse at run end.

Function
- REQ-013 inst field map SHALL be: [19] sfp_wr2pmem, [18] sfp_div, [17] sfp_acc, [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
- REQ-014 FSM states SHALL be: IDLE, QWR, KWR, KLOAD, GAP1, EXEC, GAP2, OFIFO, ACC, DIV, DONE, visited strictly in that order; DONE returns to IDLE.
- REQ-015 Any field not driven by the current state SHALL be 0.
- REQ-016 start high in IDLE SHALL enter QWR; the first QWR inst SHALL appear the next cycle; start SHALL be ignored while busy.
- REQ-017 QWR: mem_req=1, row_idx=n; when host_valid=1, inst SHALL carry qmem_wr=1 and qkmem_add=n, and n advances; when host_valid=0, qmem_wr=0 and n holds (stall, no timeout); exit after total_cycle writes.
- REQ-018 KWR SHALL behave as QWR, using kmem_wr for col writes, with n restarting at 0.
- REQ-019 KLOAD SHALL last col+2 cycles with load=1 throughout; cycles 1..col SHALL assert kmem_rd=1 with qkmem_add=cycle-1; cycles 0 and col+1 SHALL have kmem_rd=0 and qkmem_add=0.
- REQ-020 GAP1 and GAP2 SHALL each hold inst=0 for gap_cycle cycles.
- REQ-021 EXEC SHALL assert execute=1 and qmem_rd=1 for total_cycle cycles, with qkmem_add=0..total_cycle-1.
- REQ-022 OFIFO SHALL assert ofifo_rd=1 and pmem_wr=1 for total_cycle cycles, with pmem_add=0..total_cycle-1.
- REQ-023 ACC SHALL assert pmem_rd=1 and sfp_acc=1 for 2*total_cycle cycles, holding each pmem_add for 2 cycles, ascending from 0.
- REQ-024 DIV SHALL assert sfp_div=1 for the whole state.
  - The first 2 cycles SHALL be settle cycles with pmem_rd=0.
  - Then pmem_rd=1 and sfp_wr2pmem=1 for 2*total_cycle cycles, each pmem_add held 2 cycles.
- REQ-025 DONE SHALL last 1 cycle with inst=0 and done=1.
- REQ-026 Address counters SHALL be 4 bits; parameters SHALL satisfy total_cycle<=16 and col<=16; no wrap occurs within legal parameters.

Reset
- REQ-027 reset SHALL force IDLE on the next edge, regardless of the current state, with inst=0, mem_req=0, row_idx=0, busy=0, done=0, and all counters 0.
- REQ-028 start asserted in the same cycle as reset SHALL be ignored.

Configuration
- REQ-029 With SEQ_READBACK_EN defined, a state RDBK SHALL sit between OFIFO and ACC: pmem_rd=1 for 2*total_cycle cycles, each pmem_add held 2 cycles, all other fields 0.
- REQ-030 Without SEQ_READBACK_EN, OFIFO SHALL go directly to ACC and RDBK logic SHALL be absent.

Structure
- REQ-031 Package fullchip_pkg SHALL hold the inst bit-position constants, the 20-bit inst width, and the state enum.
- REQ-032 A single sub-module seq_step_cnt (load, hold-for-2 mode, terminal-count flag) SHALL generate per-state cycle and address counts.

Verification
- REQ-033 Defaults, host_valid=1, start pulse at cycle 0 -> QWR begins cycle 1; done=1 exactly at cycle 97 (113 with SEQ_READBACK_EN).
- REQ-034 QWR with host_valid low on rows 3 and 5 for 2 cycles each -> qmem_wr=0 and row_idx held during the stall; 8 writes with addresses 0..7 in order; done delayed by 4 cycles.
- REQ-035 Decode the KLOAD window -> 10 cycles of load=1; kmem_rd=1 on cycles 1..8 with qkmem_add 0..7.
- REQ-036 ACC and DIV -> each pmem_add 0..7 seen on exactly 2 consecutive cycles; sfp_div high 18 cycles; sfp_wr2pmem high 16 cycles.
- REQ-037 reset asserted mid-EXEC (qkmem_add=4) -> inst=0, busy=0 on the next cycle; a following start replays the full sequence from QWR row 0.
- REQ-038 start pulses while busy -> no effect; exactly one done per accepted start.
